// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier arbiter slice.
// Contents: FSM state encodings, default sizing constants, Booth step
// op codes and the Booth recoding helper used by the datapath.
package booth_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the {Q0, Q_-1} bit pair.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        booth_op_e op;
        case ({q0, q_m1})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Request/response bus between ALU-side clients and the shared Booth
// multiplier arbiter.
// Signals: req_valid/req_ready (per requester), req_multiplier and
// req_multiplicand (packed per-requester slices), rsp_valid/rsp_ready,
// rsp_id (owning requester) and rsp_result (signed product).
// master = client side, slave = arbiter side.
interface booth_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_multiplier;
    logic [NUM_REQ*WIDTH-1:0] req_multiplicand;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_result;

    modport master (
        output req_valid, req_multiplier, req_multiplicand, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_multiplier, req_multiplicand, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/booth_step_dp.sv
// Sequential radix-2 Booth datapath: A (WIDTH+1), Q, Q_-1 and M registers.
// Ports: clk, reset (sync active-low), load (capture operands, clear A and
// Q_-1), step (apply one add/sub + arithmetic shift), multiplier,
// multiplicand, product.
// product is the low 2*WIDTH bits of {A,Q} as they will be after the step
// currently being applied, so the controller can register the final result
// on the same edge as the last step.
module booth_step_dp
    import booth_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic             q_m1_r;
    logic [WIDTH:0]   m_r;

    booth_op_e        op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   acc_sh_s;
    logic [WIDTH-1:0] q_sh_s;
    logic             q_m1_sh_s;

    // One Booth step: recode, add/sub into the widened accumulator.
    always_comb begin
        op_s = booth_decode(q_r[0], q_m1_r);
        case (op_s)
            OP_ADD:  sum_s = acc_r + m_r;
            OP_SUB:  sum_s = acc_r - m_r;
            OP_NOP:  sum_s = acc_r;
            default: sum_s = acc_r;
        endcase
    end

    // Arithmetic right shift of {A,Q,Q_-1}: duplicate the accumulator sign.
    assign {acc_sh_s, q_sh_s, q_m1_sh_s} = {sum_s[WIDTH], sum_s, q_r};
    assign product = {acc_sh_s[WIDTH-1:0], q_sh_s};

    // Datapath registers: clear, load operands, or advance one step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_r  <= '0;
            q_r    <= '0;
            q_m1_r <= 1'b0;
            m_r    <= '0;
        end else if (load) begin
            acc_r  <= '0;
            q_r    <= multiplier;
            q_m1_r <= 1'b0;
            m_r    <= {multiplicand[WIDTH-1], multiplicand};
        end else if (step) begin
            acc_r  <= acc_sh_s;
            q_r    <= q_sh_s;
            q_m1_r <= q_m1_sh_s;
        end else begin
            acc_r  <= acc_r;
            q_r    <= q_r;
            q_m1_r <= q_m1_r;
            m_r    <= m_r;
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential Booth multiplier among NUM_REQ requesters.
// Ports: clk, reset (sync active-low), bus (slave side of
// booth_mult_arbiter_if: round-robin valid/ready requests, single tagged
// response), busy (high while a job is running or its response is held).
// Holds the IDLE/RUN/RESP FSM, round-robin pointer, step counter and the
// response registers; the arithmetic lives in booth_step_dp.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_mult_arbiter_if.slave  bus,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e               state_r;
    state_e               state_next_s;
    logic [ID_W-1:0]      ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [ID_W-1:0]      job_id_r;
    logic                 rsp_valid_r;
    logic [ID_W-1:0]      rsp_id_r;
    logic [2*WIDTH-1:0]   rsp_result_r;
    logic                 busy_r;

    logic                 found_s;
    logic [ID_W-1:0]      win_s;
    logic [ID_W-1:0]      cand_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic                 load_s;
    logic                 step_s;
    logic                 done_s;
    logic [ID_W-1:0]      ptr_next_s;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH-1:0]     win_mplier_s;
    logic [WIDTH-1:0]     win_mcand_s;

    // Round-robin search starting at ptr_r; first valid requester wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        grant_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = ID_W'((int'(ptr_r) + i) % NUM_REQ);
            if (!found_s && bus.req_valid[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant_s[win_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        ptr_next_s   = ID_W'((int'(win_s) + 1) % NUM_REQ);
        win_mplier_s = bus.req_multiplier[win_s*WIDTH +: WIDTH];
        win_mcand_s  = bus.req_multiplicand[win_s*WIDTH +: WIDTH];
    end

    // FSM next state and datapath controls.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        done_s       = 1'b0;
        req_ready_s  = '0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = grant_s;
                if (found_s) begin
                    load_s       = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (count_r == CNT_W'(1)) begin
                    done_s       = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pointer, step counter, job tag and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r        <= '0;
            count_r      <= '0;
            job_id_r     <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (load_s) begin
                count_r  <= CNT_W'(WIDTH);
                job_id_r <= win_s;
                ptr_r    <= ptr_next_s;
            end else if (step_s) begin
                count_r  <= count_r - CNT_W'(1);
            end else begin
                count_r  <= count_r;
            end
            // Result/tag change only on completion so they persist after handshake.
            if (done_s) begin
                rsp_valid_r  <= 1'b1;
                rsp_id_r     <= job_id_r;
                rsp_result_r <= product_s;
            end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
                rsp_valid_r  <= 1'b0;
            end else begin
                rsp_valid_r  <= rsp_valid_r;
            end
        end
    end

    booth_step_dp #(.WIDTH(WIDTH)) u_dp (
        .clk          (clk),
        .reset        (reset),
        .load         (load_s),
        .step         (step_s),
        .multiplier   (win_mplier_s),
        .multiplicand (win_mcand_s),
        .product      (product_s)
    );

    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed + reference-model bench for booth_mult_arbiter (NUM_REQ=4, WIDTH=8).
module tb_booth_mult_arbiter;

    logic clk;
    logic reset;
    logic busy;
    int   checks;
    int   errors;

    booth_mult_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) bus ();

    booth_mult_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [15:0] p;
        p = a * b;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_ops(input int idx, input logic [7:0] mr, input logic [7:0] md);
        bus.req_multiplier[idx*8 +: 8]   = mr;
        bus.req_multiplicand[idx*8 +: 8] = md;
    endtask

    // Issue one request, expect grant, 8-cycle latency, product and tag.
    task automatic run_op(input int idx, input logic [7:0] mr, input logic [7:0] md,
                          input logic [15:0] exp, input string tag);
        int n;
        set_ops(idx, mr, md);
        bus.req_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[idx] && n < 50) begin
            tick();
            n++;
        end
        check_eq({tag, "_grant"}, 32'(bus.req_ready[idx]), 32'd1);
        tick();
        bus.req_valid[idx] = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'd8);
        check_eq({tag, "_res"}, 32'(bus.rsp_result), 32'(exp));
        check_eq({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
        bus.rsp_ready = 1'b1;
        tick();
        check_eq({tag, "_rspdone"}, 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int g;
        int last;
        int cyc;
        int cur_id;
        int exp_order[5];
        logic [7:0] rmr;
        logic [7:0] rmd;
        int ridx;

        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.req_valid        = 4'b0000;
        bus.req_multiplier   = 32'd0;
        bus.req_multiplicand = 32'd0;
        bus.rsp_ready        = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        tick();
        tick();
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check_eq("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        tick();

        // Directed products
        run_op(0, 8'd3, 8'd5, 16'd15, "p3x5");
        run_op(1, 8'hF9, 8'd6, 16'hFFD6, "pm7x6");
        run_op(2, 8'h80, 8'h80, 16'h4000, "pm128sq");
        run_op(3, 8'd127, 8'h80, 16'hC080, "p127xm128");
        run_op(0, 8'd0, 8'hFF, 16'h0000, "p0xm1");
        check_eq("rsp_id_retained", 32'(bus.rsp_id), 32'd0);

        // Round robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ops(i, 8'(i + 2), 8'(-(i + 1)));
        end
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        g = 0;
        last = 0;
        cyc = 0;
        cur_id = 0;
        while (g < 5 && cyc < 80) begin
            if (bus.rsp_valid) begin
                check_eq("rr_res", 32'(bus.rsp_result),
                         32'(ref_prod(8'(cur_id + 2), 8'(-(cur_id + 1)))));
                check_eq("rr_id", 32'(bus.rsp_id), 32'(cur_id));
            end
            if (bus.req_ready != 4'b0000) begin
                check_eq("rr_grant", 32'(bus.req_ready), 32'(1 << exp_order[g]));
                if (g > 0) begin
                    check_eq("rr_period", 32'(cyc - last), 32'd10);
                end
                cur_id = exp_order[g];
                last = cyc;
                g++;
            end
            tick();
            cyc++;
        end
        check_eq("rr_count", 32'(g), 32'd5);

        // Back-pressure in RESP
        do_reset();
        set_ops(2, 8'd5, 8'hFD);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b1011;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq("bp_lat", 32'(cyc), 32'd8);
        for (int i = 0; i < 20; i++) begin
            check_eq("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("bp_res", 32'(bus.rsp_result), 32'hFFF1);
            check_eq("bp_id", 32'(bus.rsp_id), 32'd2);
            check_eq("bp_ready", 32'(bus.req_ready), 32'd0);
            check_eq("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("bp_release", 32'(bus.rsp_valid), 32'd0);
        check_eq("bp_next_grant", 32'(bus.req_ready), 32'b1000);
        bus.rsp_ready = 1'b0;

        // Reset in the middle of RUN
        do_reset();
        set_ops(1, 8'd9, 8'd9);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b1010;
        tick();
        tick();
        tick();
        tick();
        check_eq("mr_busy_run", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mr_grant", 32'(bus.req_ready), 32'b0010);
        run_op(1, 8'hFD, 8'd7, 16'hFFEB, "mr_op");
        bus.req_valid = 4'b0000;
        tick();
        tick();

        // Random traffic against the reference product
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            ridx = int'($urandom_range(0, 3));
            rmr  = 8'($urandom);
            rmd  = 8'($urandom);
            run_op(ridx, rmr, rmd, ref_prod(rmr, rmd), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
